// File: rtl/lfsr_dec_display.sv
// Fibonacci LFSR with load/free-run/single-step control, decimal conversion and 7-segment drive.
// Latency: value updates on the control edge; seg follows WIDTH+2 edges after a change when idle.
// No backpressure: value changes during a conversion are coalesced, latest value shown next.
module lfsr_dec_display #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'b00011101,
    parameter int               DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  step,
    input  logic                  blank_lz,
    output logic [WIDTH-1:0]      value,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  disp_valid
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1;

    // Refuse to build a configuration whose digits cannot hold the largest LFSR value.
    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("lfsr_dec_display: WIDTH must be 4..16");
        end
        if (pow10(DIGITS) <= MAX_VAL) begin : g_bad_digits
            $error("lfsr_dec_display: DIGITS too small for WIDTH");
        end
    endgenerate

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int              BCD_W    = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- LFSR ----------------
    logic [WIDTH-1:0] r_value;
    logic             r_step_d;
    logic             w_fb;
    logic             w_step_rise;
    logic             w_advance;

    assign w_fb        = ^(r_value & TAPS);
    assign w_step_rise = step & ~r_step_d;
    assign w_advance   = mode ? w_step_rise : en;

    // LFSR state: load beats advance beats hold; a zero seed is replaced by 1 to avoid lock-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= WIDTH'(1);
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
            if (load) begin
                r_value <= (seed == '0) ? WIDTH'(1) : seed;
            end else if (w_advance) begin
                r_value <= {w_fb, r_value[WIDTH-1:1]};
            end
        end
    end

    // ---------------- Converter ----------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_busy;
    logic               r_forced;
    logic [WIDTH-1:0]   r_snap;
    logic [WIDTH-1:0]   r_shr;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_last;
    logic [7*DIGITS-1:0] r_seg;
    logic               r_disp_valid;

    logic [BCD_W-1:0]        w_bcd_adj;
    logic [BCD_W+WIDTH-1:0]  w_shift;
    logic [7*DIGITS-1:0]     w_seg_new;
    logic                    w_lead;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, start strobe and busy flag.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_forced || (r_value != r_last)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = {w_bcd_adj, r_shr} << 1;

    // Segment image with optional blanking of zero digits above the most significant nonzero one.
    always_comb begin
        w_seg_new = '1;
        w_lead    = blank_lz;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (r_bcd[4*d +: 4] != 4'd0) begin
                w_lead = 1'b0;
            end
            w_seg_new[7*d +: 7] = w_lead ? 7'b1111111 : seg_decode(r_bcd[4*d +: 4]);
        end
        w_seg_new[6:0] = seg_decode(r_bcd[3:0]);
    end

    // Converter datapath: snapshot on start, shift-add-3 per SHIFT cycle, publish in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_forced     <= 1'b1;
            r_snap       <= '0;
            r_shr        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_seg        <= '1;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_snap   <= r_value;
                        r_shr    <= r_value;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_forced <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_shift[BCD_W+WIDTH-1:WIDTH];
                    r_shr <= w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_seg        <= w_seg_new;
                    r_last       <= r_snap;
                    r_disp_valid <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign value      = r_value;
    assign seg        = r_seg;
    assign busy       = w_busy;
    assign disp_valid = r_disp_valid;

endmodule

// File: tb/tb_lfsr_dec_display.sv
// Directed bench for lfsr_dec_display with WIDTH=8, TAPS=8'b00011101, DIGITS=3.
// Latency: checks seg exactly WIDTH+2 edges after each value change.
// Backpressure: none; inputs are driven #1 after each rising edge.
module tb_lfsr_dec_display;

    logic        clk;
    logic        reset;
    logic        load;
    logic [7:0]  seed;
    logic        en;
    logic        mode;
    logic        step;
    logic        blank_lz;
    logic [7:0]  value;
    logic [20:0] seg;
    logic        busy;
    logic        disp_valid;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;

    lfsr_dec_display #(
        .WIDTH  (8),
        .TAPS   (8'b00011101),
        .DIGITS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .seed       (seed),
        .en         (en),
        .mode       (mode),
        .step       (step),
        .blank_lz   (blank_lz),
        .value      (value),
        .seg        (seg),
        .busy       (busy),
        .disp_valid (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_seq [5];
        int nb;
        int nd;

        exp_seq[0] = 8'h80;
        exp_seq[1] = 8'h40;
        exp_seq[2] = 8'h20;
        exp_seq[3] = 8'h10;
        exp_seq[4] = 8'h88;

        reset = 1'b1; load = 1'b0; seed = 8'h00; en = 1'b0;
        mode = 1'b0; step = 1'b0; blank_lz = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_value", 32'(value), 32'h01);
        chk("rst_seg", 32'(seg), 32'h1FFFFF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dv", 32'(disp_valid), 32'h0);
        reset = 1'b0;

        // Forced first conversion shows "001" ten edges after reset
        nd = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nd += int'(disp_valid);
            if (k == 9)  chk("boot_seg_pre", 32'(seg), 32'h1FFFFF);
            if (k == 10) begin
                chk("boot_seg", 32'(seg), 32'({D0, D0, D1}));
                chk("boot_dv", 32'(disp_valid), 32'h1);
            end
        end
        chk("boot_dv_count", 32'(nd), 32'd1);
        chk("boot_value", 32'(value), 32'h01);

        // Load wins over enable on the same edge
        seed = 8'h01; load = 1'b1; en = 1'b1;
        tick();
        chk("load_prio", 32'(value), 32'h01);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("freerun_%0d", i), 32'(value), 32'(exp_seq[i]));
        end
        en = 1'b0;

        // Zero seed guard
        seed = 8'h00; load = 1'b1;
        tick();
        load = 1'b0;
        chk("zero_seed", 32'(value), 32'h01);

        // Single-step: held step gives one advance, en ignored
        mode = 1'b1; en = 1'b1; step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("step_hold_%0d", i), 32'(value), 32'h80);
        end
        step = 1'b0;
        tick();
        chk("step_low", 32'(value), 32'h80);
        step = 1'b1;
        tick();
        chk("step_again", 32'(value), 32'h40);
        step = 1'b0; en = 1'b0; mode = 1'b0;

        // Let the converter settle on 0x40 = "064"
        for (int i = 0; i < 22; i++) tick();
        chk("settle_seg", 32'(seg), 32'({D0, D6, D4}));
        chk("settle_busy", 32'(busy), 32'h0);

        // 0xFF -> "255": busy for 9 cycles, one disp_valid
        seed = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        chk("ff_busy_idle", 32'(busy), 32'h0);
        nb = 0;
        nd = 0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            nb += int'(busy);
            nd += int'(disp_valid);
            if (k == 9)  chk("ff_seg_pre", 32'(seg), 32'({D0, D6, D4}));
            if (k == 10) chk("ff_seg", 32'(seg), 32'({D2, D5, D5}));
        end
        chk("ff_busy_cycles", 32'(nb), 32'd9);
        chk("ff_dv_count", 32'(nd), 32'd1);

        // 0x07 with leading-zero blanking
        blank_lz = 1'b1;
        seed = 8'h07; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk("blank_seg", 32'(seg), 32'({BL, BL, D7}));
        chk("blank_value", 32'(value), 32'h07);
        blank_lz = 1'b0;

        // Reset in the 4th SHIFT cycle aborts the conversion
        seed = 8'h55; load = 1'b1;
        tick();
        load = 1'b0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nd += int'(disp_valid);
        end
        chk("abort_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_seg", 32'(seg), 32'h1FFFFF);
        chk("abort_dv", 32'(disp_valid), 32'h0);
        chk("abort_value", 32'(value), 32'h01);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 10) nd += int'(disp_valid);
            if (k == 9) chk("abort_seg_pre", 32'(seg), 32'h1FFFFF);
            if (k == 10) begin
                chk("abort_seg_001", 32'(seg), 32'({D0, D0, D1}));
                chk("abort_dv_new", 32'(disp_valid), 32'h1);
            end
        end
        chk("abort_no_dv", 32'(nd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_dec_display.md
Name: lfsr_dec_display

Overview:
- Parametrised successor to the team's 8-bit LFSR-plus-decimal-display block.
- Generates pseudo-random values with a Fibonacci LFSR of configurable width and tap mask.
- Supports free-run and single-step modes, and guards against the all-zero lock-up state.
- Converts the current value to decimal with a multi-cycle shift-add-3 (double-dabble) converter and drives active-low 7-segment digits, with optional leading-zero blanking.

Parameters:
- WIDTH, 8: LFSR width in bits; 4..16.
- TAPS, 8'b00011101: feedback mask, WIDTH bits; bit i set means value[i] is XORed into the feedback.
- DIGITS, 3: number of decimal digits driven. Must be >= ceil(WIDTH*log10(2)); elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load seed on this edge.
- seed  in  WIDTH  seed value.
- en  in  1  advance enable, used in mode 0.
- mode  in  1  0 = free-run, 1 = single-step.
- step  in  1  step request, used in mode 1; rising-edge detected internally.
- blank_lz  in  1  1 = blank leading zero digits.
- value  out  WIDTH  current LFSR state.
- seg  out  7*DIGITS  active-low gfedcba segments. seg[6:0] is the units digit; seg[13:7] is tens; and so on.
- busy  out  1  converter active (SHIFT or DONE state).
- disp_valid  out  1  one-cycle pulse when seg has just been updated.

Behaviour:
- Reset (synchronous, priority over everything):
  - value=1, seg all 1s (all segments off), busy=0, disp_valid=0.
  - Converter goes to IDLE with a forced-conversion flag set.
  - step edge-detector register cleared.
  - Reset during a conversion aborts it; no disp_valid is issued.
- LFSR update priority, per edge: load > advance > hold.
  - load: value <= (seed==0) ? 1 : seed. The zero guard prevents lock-up.
  - advance: fb = XOR-reduce(value & TAPS); value <= {fb, value[WIDTH-1:1]}.
  - mode 0: advance on every edge where en=1.
  - mode 1: advance once on the edge where step=1 and step_d=0 (step_d is step registered last cycle). en is ignored. Holding step high gives exactly one advance.
  - A mode change takes effect on the next edge. step_d updates in both modes.
- Converter FSM:
  - IDLE: if forced flag set, or value != last_shown:
    - snapshot <= value, bcd <= 0, cnt <= 0, clear forced flag, go to SHIFT.
    - busy asserts from the next cycle.
  - SHIFT: each cycle, every 4-bit BCD digit >= 5 gets +3; then {bcd, snapshot} shifts left by 1 (MSB first). cnt increments; after WIDTH shifts, go to DONE.
  - DONE:
    - seg <= decode(bcd); last_shown <= snapshot; disp_valid=1 for this cycle only; go to IDLE.
    - busy is low again in IDLE.
  - Latency: if the converter is IDLE when value changes, seg reflects the new value WIDTH+2 edges after the edge that updated value (10 for WIDTH=8).
  - Values changing during a conversion are not tracked individually. On return to IDLE the latest value is converted; intermediate values may never be displayed.
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blanking is sampled in DONE. With blank_lz=1, every digit above the most significant nonzero digit is driven 1111111. The units digit is always shown, so 0 displays as a single "0".
- BCD digits never exceed 9 given the DIGITS constraint; no overflow path exists.

Test Plan:
- Reset, then idle 12 cycles, blank_lz=0 -> value=8'h01; disp_valid pulses once at cycle 10; seg = {1000000,1000000,1111001} ("001").
- load seed=8'h01, then mode=0, en=1 for 5 cycles -> value sequence 80,40,20,10,88 (hex). With load=1 and en=1 on the same edge, load wins.
- load seed=0 -> value=8'h01 on the next cycle.
- mode=1, step held high 5 cycles from value 8'h01 -> exactly one advance to 8'h80. Drop step for 1 cycle, raise again -> 8'h40.
- load 8'hFF, en=0, wait 10 cycles -> seg2=0100100, seg1=0010010, seg0=0010010 ("255"); busy high for 9 cycles; one disp_valid pulse.
- load 8'h07 with blank_lz=1 -> seg2=seg1=1111111, seg0=1111000.
- Reset asserted in the 4th SHIFT cycle -> next cycle busy=0, seg all 1s, no disp_valid; after release, "001" appears 10 cycles later.
